// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler.
//   state_t       : frame sequencer states
//   SCREEN_W      : visible screen width in pixels
//   *_DFLT        : default spawn column, largest legal y, frames between spawns
//   fold_y()      : folds an out-of-range LFSR y back into 0..Y_MAX
package obstacle_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_NEXT, S_SPAWN, S_FIN
  } state_t;

  localparam int         SCREEN_W       = 160;
  localparam logic [7:0] X_START_DFLT   = 8'(SCREEN_W - 1);
  localparam logic [5:0] Y_MAX_DFLT     = 6'd48;
  localparam int         SPAWN_GAP_DFLT = 40;

  // A 6-bit LFSR value can exceed Y_MAX by at most 63-Y_MAX; subtracting
  // once keeps the spread cheap without a modulo.
  function automatic logic [5:0] fold_y(input logic [5:0] ry, input logic [5:0] ymax);
    return (ry > ymax) ? (ry - ymax) : ry;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_slot_alloc.sv
// slot_alloc: combinational lowest-index free-slot finder.
//   i_active : per-slot occupied flags
//   o_idx    : index of the lowest free slot (0 when none)
//   o_found  : 1 when at least one slot is free
module slot_alloc
  import obstacle_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] i_active,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_found
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_active[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: once per frame, walks every obstacle slot, erases and
// redraws active obstacles one column to the left through a shared sprite
// drawer, retires obstacles that reach x=0, then spawns a new one when the
// spawn counter has run out.
//   clk, reset    : clock, asynchronous active-high reset
//   enable        : gates the start of new frames only
//   frame_tick    : 60 Hz frame strobe; dropped (overrun pulse) when busy
//   rand_y        : LFSR y, sampled at spawn
//   draw_*        : request/coordinates/erase flag to drawer, draw_done back
//   active_mask   : per-slot occupied flags
//   frame_done    : one-cycle pulse at frame end
//   overrun       : one-cycle pulse for a frame_tick dropped while busy
// An empty slot costs one cycle: its ERASE visit also advances the index.
// An active slot costs erase-wait + MOVE + draw-wait + NEXT.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int         NUM_SLOTS = 4,
  parameter logic [7:0] X_START   = X_START_DFLT,
  parameter logic [5:0] Y_MAX     = Y_MAX_DFLT,
  parameter int         SPAWN_GAP = SPAWN_GAP_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [5:0]           rand_y,
  output logic                 draw_req,
  output logic [7:0]           draw_x,
  output logic [5:0]           draw_y,
  output logic                 draw_erase,
  input  logic                 draw_done,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int             IDX_W      = $clog2(NUM_SLOTS);
  localparam logic [7:0]     GAP_RELOAD = 8'(SPAWN_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  state_t                      r_state, w_next;
  logic [IDX_W-1:0]            r_idx, w_idx_n;
  logic [NUM_SLOTS-1:0][7:0]   r_x;
  logic [NUM_SLOTS-1:0][5:0]   r_y;
  logic [NUM_SLOTS-1:0]        r_active;
  logic [7:0]                  r_cnt;
  logic                        r_draw_req, r_draw_erase, r_frame_done, r_overrun;
  logic [7:0]                  r_draw_x;
  logic [5:0]                  r_draw_y;

  logic                        w_done, w_last, w_cur_act, w_req_n, w_found;
  logic [7:0]                  w_cur_x;
  logic [IDX_W-1:0]            w_free;

  // draw_done only counts while a request is actually outstanding.
  assign w_done    = r_draw_req & draw_done;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_cur_act = r_active[r_idx];
  assign w_cur_x   = r_x[r_idx];

  slot_alloc #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) u_alloc (
    .i_active (r_active),
    .o_idx    (w_free),
    .o_found  (w_found)
  );

  always_comb begin
    w_next  = r_state;
    w_idx_n = r_idx;
    case (r_state)
      S_IDLE:  if (frame_tick && enable) begin
                 w_next  = S_ERASE;
                 w_idx_n = '0;
               end
      S_ERASE: if (!w_cur_act) begin
                 w_next  = w_last ? S_SPAWN : S_ERASE;
                 w_idx_n = r_idx + 1'b1;
               end else if (w_done) begin
                 w_next  = S_MOVE;
               end
      S_MOVE:  w_next = (w_cur_x == 8'd0) ? S_NEXT : S_DRAW;
      S_DRAW:  if (w_done) w_next = S_NEXT;
      S_NEXT:  begin
                 w_next  = w_last ? S_SPAWN : S_ERASE;
                 w_idx_n = r_idx + 1'b1;
               end
      S_SPAWN: w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Request is a pure function of where we are heading, so it drops on the
    // edge that samples draw_done and rises on entry to a drawing state.
    w_req_n = (w_next == S_DRAW) || ((w_next == S_ERASE) && r_active[w_idx_n]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_n;
    end
  end

  // Slot storage and spawn counter. A freed slot is eligible in the SPAWN
  // step of the same frame; spawned slots are first drawn next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_x[i] <= X_START;
        r_y[i] <= 6'd0;
      end
      r_active <= '0;
      r_cnt    <= 8'd0;
    end else begin
      if (r_state == S_MOVE) begin
        if (w_cur_x == 8'd0) r_active[r_idx] <= 1'b0;
        else                 r_x[r_idx]      <= w_cur_x - 8'd1;
      end
      if (r_state == S_SPAWN) begin
        if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else if (w_found) begin
          r_active[w_free] <= 1'b1;
          r_x[w_free]      <= X_START;
          r_y[w_free]      <= fold_y(rand_y, Y_MAX);
          r_cnt            <= GAP_RELOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_draw_req   <= 1'b0;
      r_draw_x     <= 8'd0;
      r_draw_y     <= 6'd0;
      r_draw_erase <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_draw_req   <= w_req_n;
      r_frame_done <= (w_next == S_FIN);
      r_overrun    <= frame_tick && (r_state != S_IDLE);
      // Coordinates latch only on the rising edge of a request so they stay
      // frozen for the whole handshake.
      if (w_req_n && !r_draw_req) begin
        if (w_next == S_DRAW) begin
          r_draw_x     <= w_cur_x - 8'd1;
          r_draw_y     <= r_y[r_idx];
          r_draw_erase <= 1'b0;
        end else begin
          r_draw_x     <= r_x[w_idx_n];
          r_draw_y     <= r_y[w_idx_n];
          r_draw_erase <= 1'b1;
        end
      end
    end
  end

  assign draw_req    = r_draw_req;
  assign draw_x      = r_draw_x;
  assign draw_y      = r_draw_y;
  assign draw_erase  = r_draw_erase;
  assign active_mask = r_active;
  assign frame_done  = r_frame_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

  localparam int NS  = 4;
  localparam int GAP = 2;
  localparam int XS  = 159;
  localparam int YM  = 48;

  logic          clk = 1'b0;
  logic          reset, enable, frame_tick, draw_done;
  logic [5:0]    rand_y;
  logic          draw_req, draw_erase, frame_done, overrun;
  logic [7:0]    draw_x;
  logic [5:0]    draw_y;
  logic [NS-1:0] active_mask;

  always #5 clk = ~clk;

  obstacle_scheduler #(.NUM_SLOTS(NS), .X_START(8'd159), .Y_MAX(6'd48), .SPAWN_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick), .rand_y(rand_y),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_erase(draw_erase),
    .draw_done(draw_done), .active_mask(active_mask), .frame_done(frame_done), .overrun(overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: obstacle list plus expected drawer traffic.
  typedef struct { int erase; int x; int y; } draw_t;
  draw_t exp_q[$];
  int    done_q[$];
  int    mask_q[$];
  int    mx[NS], my[NS];
  bit    ma[NS];
  int    mcnt;
  int    n_frames = 0;
  bit    mon_en = 0, drawer_en = 1, late_pulse = 0;
  int    dly = 1;
  int    ovr_cyc = -1;

  function automatic draw_t mk(input int e, input int x, input int y);
    draw_t t; t.erase = e; t.x = x; t.y = y; return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin ma[i] = 0; mx[i] = XS; my[i] = 0; end
    mcnt = 0;
    exp_q.delete(); done_q.delete(); mask_q.delete();
  endtask

  // Drawer: pulses draw_done on the dly-th cycle a request is seen.
  initial begin
    int cnt = 0;
    draw_done = 1'b0;
    forever begin
      @(negedge clk);
      draw_done = 1'b0;
      if (late_pulse) draw_done = 1'b1;
      else if (drawer_en && draw_req) begin
        cnt++;
        if (cnt >= dly) begin draw_done = 1'b1; cnt = 0; end
      end else cnt = 0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    draw_t cur;
    bit prev = 0;
    cur = mk(0, 0, 0);
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (draw_req && !prev) begin
          if (exp_q.size() == 0) chk("unexpected_draw_req", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("draw_x", int'(draw_x), cur.x);
            chk("draw_y", int'(draw_y), cur.y);
            chk("draw_erase", int'(draw_erase), cur.erase);
          end
        end else if (draw_req) begin
          chk("draw_stable", int'({draw_erase, draw_y, draw_x}), cur.erase * 16384 + cur.y * 256 + cur.x);
        end
        if (frame_done) begin
          if (done_q.size() == 0) chk("unexpected_frame_done", 1, 0);
          else begin
            chk("frame_done_cycle", cyc, done_q.pop_front());
            chk("active_mask", int'(active_mask), mask_q.pop_front());
          end
          n_frames++;
        end
        if (overrun) chk("overrun_cycle", cyc, ovr_cyc);
      end
      prev = draw_req;
    end
  end

  task automatic run_frame(input int d, input int ry, input bit inject, input bit drop_en);
    int lat, m, target;
    bit inj;
    dly = d;
    lat = 3;
    for (int i = 0; i < NS; i++) begin
      if (ma[i]) begin
        exp_q.push_back(mk(1, mx[i], my[i]));
        if (mx[i] == 0) begin ma[i] = 0; lat += d + 2; end
        else begin mx[i]--; exp_q.push_back(mk(0, mx[i], my[i])); lat += 2 * d + 2; end
      end else lat += 1;
    end
    if (mcnt == 0) begin
      for (int i = 0; i < NS; i++) begin
        if (!ma[i]) begin
          ma[i] = 1; mx[i] = XS; my[i] = (ry > YM) ? ry - YM : ry; mcnt = GAP - 1;
          break;
        end
      end
    end else mcnt--;
    m = 0;
    for (int i = 0; i < NS; i++) if (ma[i]) m |= (1 << i);
    mask_q.push_back(m);

    @(negedge clk);
    rand_y = 6'(ry); enable = 1'b1; frame_tick = 1'b1;
    done_q.push_back(cyc + lat - 1);
    @(negedge clk);
    frame_tick = 1'b0;
    if (drop_en) enable = 1'b0;
    target = n_frames + 1;
    inj = 0;
    for (int k = 0; k < 2000 && n_frames < target; k++) begin
      if (inject && !inj && draw_req) begin
        frame_tick = 1'b1; ovr_cyc = cyc + 1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("overrun_pulse", int'(overrun), 1);
        inj = 1;
      end else @(negedge clk);
    end
    if (n_frames < target) chk("frame_timeout", 0, 1);
    enable = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; rand_y = 6'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_draw_req", int'(draw_req), 0);
    chk("rst_draw_x", int'(draw_x), 0);
    chk("rst_draw_y", int'(draw_y), 0);
    chk("rst_draw_erase", int'(draw_erase), 0);
    chk("rst_active_mask", int'(active_mask), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    mon_en = 1;

    // Tick with enable low must not start a frame.
    @(negedge clk); frame_tick = 1'b1; enable = 1'b0;
    @(negedge clk); frame_tick = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_frame_when_disabled", n_frames, 0);

    run_frame(1, 20, 0, 0);                       // first spawn: slot0 (159,20)
    run_frame(5, int'($urandom_range(0, 63)), 1, 0); // erase/draw with slow drawer + overrun
    run_frame(2, 60, 0, 1);                       // spawn with y folded 60 -> 12
    for (int f = 3; f < 175; f++)                 // fills slots, retires at x=0, respawns
      run_frame(int'($urandom_range(1, 4)), int'($urandom_range(0, 63)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    chk("draw_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);

    // Reset in the middle of a handshake.
    mon_en = 0; drawer_en = 0;
    @(negedge clk); enable = 1'b1; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    for (int k = 0; k < 50 && !draw_req; k++) @(negedge clk);
    chk("req_before_reset", int'(draw_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_draw_req", int'(draw_req), 0);
    chk("async_rst_active_mask", int'(active_mask), 0);
    chk("async_rst_frame_done", int'(frame_done), 0);
    @(negedge clk); reset = 1'b0; late_pulse = 1;
    @(negedge clk); late_pulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("late_done_ignored", int'(draw_req), 0);
    end
    chk("post_rst_mask", int'(active_mask), 0);

    // Counter is back at 0, so the first frame after reset spawns again.
    model_reset();
    drawer_en = 1; mon_en = 1;
    run_frame(1, 20, 0, 0);
    chk("final_queue_drained", exp_q.size() + done_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
